// File: rtl/jtag_led_pkg.sv
// rtl/jtag_led_pkg.sv - opcodes, LED modes and helpers for the JTAG LED engine
package jtag_led_pkg;

  typedef enum logic [1:0] {OP_LOAD_LO, OP_LOAD_HI, OP_MODE, OP_SPEED} opcode_e;
  typedef enum logic [1:0] {M_STATIC, M_BLINK, M_ROTATE, M_COUNT} mode_e;

  localparam logic [5:0] RESET_SPEED = 6'd8;

  function automatic logic [7:0] rotl8(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  function automatic logic [7:0] rotr8(input logic [7:0] v);
    return {v[0], v[7:1]};
  endfunction

endpackage

// File: rtl/cdc_toggle_sync.sv
// rtl/cdc_toggle_sync.sv - toggle synchroniser with arm window, emits a one-cycle pulse plus captured data
module cdc_toggle_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              toggle_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              pulse_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_MAX + 1);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   pulse_q;
  logic [ARM_W-1:0]       arm_q;
  logic [DATA_W-1:0]      data_q;
  logic                   armed;
  logic                   edge_seen;

  // prev_q follows the synchroniser even while disarmed, so the level at release is never an edge
  assign armed     = (arm_q == ARM_W'(ARM_MAX));
  assign edge_seen = sync_q[SYNC_STAGES-1] ^ prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
      arm_q   <= '0;
      data_q  <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], toggle_i};
      prev_q  <= sync_q[SYNC_STAGES-1];
      pulse_q <= armed & edge_seen;
      if (!armed) arm_q <= arm_q + ARM_W'(1);
      if (armed && edge_seen) data_q <= data_i;
    end
  end

  assign pulse_o = pulse_q;
  assign data_o  = data_q;

endmodule

// File: rtl/jtag_led_engine.sv
// rtl/jtag_led_engine.sv - decodes JTAG command bytes and drives LEDR patterns
// JTAG_LED_SW_OVERRIDE_EN: sw[0] freezes stepping, sw[1] reverses ROTATE/COUNT direction.
module jtag_led_engine
  import jtag_led_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLOCK_50,
  input  logic       aclr,
  input  logic [7:0] cmd_data,
  input  logic       cmd_toggle,
  input  logic [3:0] sw,
  output logic [7:0] LEDR,
  output logic       cmd_ack,
  output logic [1:0] mode
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PRESC_W  = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("TICK_DIV must be >= 2");
  end

  logic              cmd_valid;
  logic [7:0]        cmd_byte;
  logic              freeze;
  logic              dir_rev;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [5:0]        step_cnt_q, step_cnt_d, speed_q, speed_d, speed_eff;
  logic [7:0]        pattern_q, pattern_d, work_q, work_d, led_q, led_d;
  logic              phase_q, phase_d, ack_q;
  mode_e             mode_q, mode_d;
  logic              tick, step;
  opcode_e           op;
  logic [5:0]        arg;

  cdc_toggle_sync #(.SYNC_STAGES(SYNC_STAGES), .DATA_W(8)) u_sync (
    .clk      (CLOCK_50),
    .rst      (aclr),
    .toggle_i (cmd_toggle),
    .data_i   (cmd_data),
    .pulse_o  (cmd_valid),
    .data_o   (cmd_byte)
  );

`ifdef JTAG_LED_SW_OVERRIDE_EN
  logic [1:0] sw_meta_q, sw_sync_q;
  logic       unused_sw_hi;
  assign unused_sw_hi = ^sw[3:2];
  always_ff @(posedge CLOCK_50 or posedge aclr) begin
    if (aclr) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw[1:0];
      sw_sync_q <= sw_meta_q;
    end
  end
  assign freeze  = sw_sync_q[0];
  assign dir_rev = sw_sync_q[1];
`else
  logic unused_sw;
  assign unused_sw = ^sw;
  assign freeze    = 1'b0;
  assign dir_rev   = 1'b0;
`endif

  assign op        = opcode_e'(cmd_byte[7:6]);
  assign arg       = cmd_byte[5:0];
  assign speed_eff = (speed_q == 6'd0) ? 6'd1 : speed_q;
  assign tick      = (presc_q == PRESC_W'(TICK_DIV - 1));

  always_ff @(posedge CLOCK_50 or posedge aclr) begin
    if (aclr) begin
      presc_q    <= '0;
      step_cnt_q <= '0;
      speed_q    <= RESET_SPEED;
      pattern_q  <= '0;
      work_q     <= '0;
      phase_q    <= 1'b0;
      mode_q     <= M_STATIC;
      led_q      <= '0;
      ack_q      <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      step_cnt_q <= step_cnt_d;
      speed_q    <= speed_d;
      pattern_q  <= pattern_d;
      work_q     <= work_d;
      phase_q    <= phase_d;
      mode_q     <= mode_d;
      led_q      <= led_d;
      ack_q      <= cmd_valid;
    end
  end

  always_comb begin
    presc_d    = tick ? '0 : presc_q + PRESC_W'(1);
    step       = 1'b0;
    step_cnt_d = step_cnt_q;
    if (tick && !freeze) begin
      if (step_cnt_q == speed_eff - 6'd1) begin
        step       = 1'b1;
        step_cnt_d = '0;
      end else begin
        step_cnt_d = step_cnt_q + 6'd1;
      end
    end
    pattern_d = pattern_q;
    work_d    = work_q;
    phase_d   = phase_q;
    mode_d    = mode_q;
    speed_d   = speed_q;
    // a command in the same cycle as a step suppresses that step
    if (cmd_valid) begin
      unique case (op)
        OP_LOAD_LO: pattern_d[3:0] = arg[3:0];
        OP_LOAD_HI: pattern_d[7:4] = arg[3:0];
        OP_MODE: begin
          mode_d     = mode_e'(arg[1:0]);
          phase_d    = 1'b0;
          step_cnt_d = '0;
          work_d     = (mode_d == M_ROTATE) ? pattern_q : 8'h00;
        end
        OP_SPEED: begin
          speed_d    = arg;
          step_cnt_d = '0;
        end
      endcase
      if (mode_q == M_ROTATE && (op == OP_LOAD_LO || op == OP_LOAD_HI)) work_d = pattern_d;
    end else if (step) begin
      unique case (mode_q)
        M_BLINK:  phase_d = ~phase_q;
        M_ROTATE: work_d  = dir_rev ? rotr8(work_q) : rotl8(work_q);
        M_COUNT:  work_d  = dir_rev ? work_q - 8'd1 : work_q + 8'd1;
        default:  ;
      endcase
    end
  end

  always_comb begin
    unique case (mode_d)
      M_STATIC: led_d = pattern_d;
      M_BLINK:  led_d = phase_d ? pattern_d : 8'h00;
      default:  led_d = work_d;
    endcase
  end

  assign LEDR    = led_q;
  assign cmd_ack = ack_q;
  assign mode    = mode_q;

endmodule

// File: tb/tb_jtag_led_engine.sv
// tb/tb_jtag_led_engine.sv - scoreboard bench for jtag_led_engine (tick every 10 cycles)
module tb_jtag_led_engine;

  logic       clk = 1'b0;
  logic       aclr = 1'b1;
  logic       cmd_toggle = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic [3:0] sw = 4'h0;
  logic [7:0] LEDR;
  logic       cmd_ack;
  logic [1:0] mode;

  typedef struct {
    logic [7:0] val;
    int         gap;
  } led_exp_t;

  led_exp_t   led_q[$];
  logic [1:0] ack_q[$];
  led_exp_t   e;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         last_chg = 0;
  int         acks = 0;
  int         ack_before;
  logic [7:0] last_led = 8'h00;

  always #5 clk = ~clk;

  jtag_led_engine #(.CLK_HZ(100), .TICK_HZ(10), .SYNC_STAGES(2)) dut (
    .CLOCK_50   (clk),
    .aclr       (aclr),
    .cmd_data   (cmd_data),
    .cmd_toggle (cmd_toggle),
    .sw         (sw),
    .LEDR       (LEDR),
    .cmd_ack    (cmd_ack),
    .mode       (mode)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_led(input logic [7:0] v, input int gap);
    led_exp_t x;
    x.val = v;
    x.gap = gap;
    led_q.push_back(x);
  endtask

  // caller must be at a negedge; next command may follow 4 cycles later
  task automatic send(input logic [7:0] c, input logic [1:0] m);
    ack_q.push_back(m);
    cmd_data   = c;
    cmd_toggle = ~cmd_toggle;
    repeat (4) @(negedge clk);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (led_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain_led_queue", led_q.size(), 0);
    led_q.delete();
  endtask

  always @(negedge clk) begin
    if (aclr) begin
      last_led = LEDR;
      last_chg = cyc;
    end else begin
      if (cmd_ack) begin
        acks++;
        if (ack_q.size() == 0) check("unexpected_ack", 1, 0);
        else check("ack_mode", mode, ack_q.pop_front());
      end
      if (LEDR !== last_led) begin
        if (led_q.size() == 0) begin
          check("unexpected_led", LEDR, last_led);
        end else begin
          e = led_q.pop_front();
          check("led_value", LEDR, e.val);
          if (e.gap != 0) check("led_gap", cyc - last_chg, e.gap);
        end
        last_led = LEDR;
        last_chg = cyc;
      end
    end
  end

  initial begin
    #600_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ledr", LEDR, 0);
    check("rst_mode", mode, 0);
    check("rst_ack", cmd_ack, 0);
    aclr = 1'b0;
    repeat (5) @(negedge clk);

    // load 0xA5, checking toggle->LEDR latency on the second byte
    push_led(8'h05, 0);
    send(8'h05, 2'd0);
    push_led(8'hA5, 0);
    ack_q.push_back(2'd0);
    cmd_data   = 8'h4A;
    cmd_toggle = ~cmd_toggle;
    repeat (3) @(posedge clk);
    #1 check("lat_edge3_ledr", LEDR, 8'h05);
    @(posedge clk);
    #1 check("lat_edge4_ledr", LEDR, 8'hA5);
    check("lat_edge4_ack", cmd_ack, 1);
    check("lat_mode", mode, 0);
    @(negedge clk);

    // rotate 0x81 at speed 1
    push_led(8'hA1, 0);
    send(8'h01, 2'd0);
    push_led(8'h81, 0);
    send(8'h48, 2'd0);
    send(8'hC1, 2'd0);
    push_led(8'h03, 0);
    push_led(8'h06, 10);
    push_led(8'h0C, 10);
    push_led(8'h18, 10);
    push_led(8'h30, 10);
    push_led(8'h60, 10);
    push_led(8'hC0, 10);
    push_led(8'h81, 10);
    send(8'h82, 2'd2);
    drain(200);

    // speed 0 behaves as 1; count wraps FF->00
    send(8'hC0, 2'd2);
    push_led(8'h00, 0);
    for (int i = 1; i <= 256; i++) push_led(i[7:0], (i == 1) ? 0 : 10);
    send(8'h83, 2'd3);
    drain(3000);

    // blink 0xA5 at speed 2: 20 cycles dark, 20 lit
    push_led(8'h01, 10);
    push_led(8'h00, 0);
    push_led(8'hA5, 0);
    push_led(8'h00, 20);
    push_led(8'hA5, 20);
    push_led(8'h00, 20);
    send(8'h05, 2'd3);
    send(8'h4A, 2'd3);
    send(8'hC2, 2'd3);
    send(8'h81, 2'd1);
    drain(300);

    // reset mid-rotate, toggle high across release
    push_led(8'hA5, 0);
    push_led(8'h4B, 0);
    send(8'h82, 2'd2);
    drain(200);
    aclr = 1'b1;
    #1;
    check("aclr_ledr_now", LEDR, 0);
    check("aclr_mode_now", mode, 0);
    cmd_toggle = 1'b1;
    repeat (2) @(negedge clk);
    aclr = 1'b0;
    ack_before = acks;
    repeat (20) @(negedge clk);
    check("release_no_ack", acks, ack_before);
    check("release_ledr", LEDR, 0);
    check("release_mode", mode, 0);

    // switch overrides during rotate
    push_led(8'h01, 0);
    send(8'h01, 2'd0);
    push_led(8'h81, 0);
    send(8'h48, 2'd0);
    send(8'hC1, 2'd0);
    push_led(8'h03, 0);
    push_led(8'h06, 10);
    push_led(8'h0C, 10);
    send(8'h82, 2'd2);
    drain(200);
`ifdef JTAG_LED_SW_OVERRIDE_EN
    sw = 4'h1;
    repeat (50) @(negedge clk);
    check("freeze_ledr", LEDR, 8'h0C);
    push_led(8'h06, 0);
    push_led(8'h03, 10);
    push_led(8'h81, 10);
    push_led(8'hC0, 10);
    push_led(8'h60, 10);
    sw = 4'h2;
    drain(200);
`else
    push_led(8'h18, 10);
    push_led(8'h30, 10);
    push_led(8'h60, 10);
    sw = 4'h3;
    drain(200);
`endif

    repeat (5) @(negedge clk);
    check("ack_queue_empty", ack_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
